// File: rtl/core_rrv_fab_mem_agent_pkg.sv
// Shared fabric transaction types for the remote-tile memory responder,
// plus its default out-of-range read pattern and a saturating counter helper.
package core_rrv_fab_mem_agent_pkg;

  typedef logic [7:0] t_tile_id;

  typedef enum logic [1:0] {
    WR     = 2'd0,
    RD     = 2'd1,
    RD_RSP = 2'd2
  } t_opcode;

  typedef struct packed {
    logic [31:0] address;
    t_opcode     opcode;
    logic [31:0] data;
    logic [31:0] requestor_id;
    logic [1:0]  next_tile_fifo_arb_id;
  } t_tile_trans;

  localparam logic [31:0] OOR_RD_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/core_rrv_fab_mem_agent_if.sv
// Request/response fabric link between the core (master) and the memory agent (slave).
interface core_rrv_fab_mem_agent_if;
  import core_rrv_fab_mem_agent_pkg::*;

  // Both channels use valid/ready: a transfer happens on a posedge where valid
  // and ready are both 1; the source holds valid and payload stable until then,
  // and ready never depends combinationally on valid.
  logic        ReqValid;
  t_tile_trans Req;
  logic        ReqReady;
  logic        RspValid;
  t_tile_trans Rsp;
  logic        RspReady;

  modport slave (
    input  ReqValid, Req, RspReady,
    output ReqReady, RspValid, Rsp
  );

  modport master (
    output ReqValid, Req, RspReady,
    input  ReqReady, RspValid, Rsp
  );

endinterface

// File: rtl/core_rrv_fab_rsp_fifo.sv
// Registered-output response FIFO for fabric transactions; a push is visible
// at the output the cycle after it lands (no fall-through).
module core_rrv_fab_rsp_fifo
  import core_rrv_fab_mem_agent_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          push_i,
  input  t_tile_trans   push_data_i,
  input  logic          pop_i,
  output t_tile_trans   pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  t_tile_trans   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A pop frees the slot in the same edge, so a full FIFO may still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/core_rrv_fab_mem_agent.sv
// Remote-tile memory responder: WR updates a local word array, RD returns an
// RD_RSP after a fixed latency through a credit-protected response FIFO.
module core_rrv_fab_mem_agent
  import core_rrv_fab_mem_agent_pkg::*;
#(
  parameter int          MEM_WORDS      = 1024,
  parameter int          RSP_LATENCY    = 3,
  parameter int          RSP_FIFO_DEPTH = 4,
  parameter logic [31:0] OOR_RD_DATA    = OOR_RD_DATA_DEFAULT
) (
  input  logic                        Clock,
  input  logic                        Rst,
  input  t_tile_id                    local_tile_id,
  core_rrv_fab_mem_agent_if.slave     fab,
  output logic                        AddrErr,
  output logic [15:0]                 WrCnt,
  output logic [15:0]                 RdCnt
);

  localparam int          IDX_W       = $clog2(MEM_WORDS);
  localparam int          CNT_W       = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [24:0] RANGE_BYTES = 25'(MEM_WORDS * 4);

  logic [31:0]              mem_q [MEM_WORDS];
  logic [RSP_LATENCY-1:0]   pipe_vld_q;
  t_tile_trans              pipe_trans_q [RSP_LATENCY];
  logic                     addr_err_q, addr_err_d;
  logic [15:0]              wr_cnt_q, wr_cnt_d;
  logic [15:0]              rd_cnt_q, rd_cnt_d;

  logic                     accept, is_wr, is_rd, in_range, misaligned;
  logic [IDX_W-1:0]         idx;
  t_tile_trans              rd_rsp;
  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  int                       pipe_occ;

  assign accept     = fab.ReqValid && fab.ReqReady;
  assign is_wr      = (fab.Req.opcode == WR);
  assign is_rd      = (fab.Req.opcode == RD);
  assign in_range   = ({1'b0, fab.Req.address[23:0]} < RANGE_BYTES);
  assign misaligned = (fab.Req.address[1:0] != 2'b00);
  assign idx        = fab.Req.address[IDX_W+1:2];

  // Every RD in flight holds a FIFO slot, so the FIFO can never be pushed while full.
  always_comb begin
    pipe_occ = 0;
    for (int i = 0; i < RSP_LATENCY; i++) pipe_occ += int'(pipe_vld_q[i]);
  end

  assign fab.ReqReady = !fifo_full && ((int'(fifo_count) + pipe_occ) < RSP_FIFO_DEPTH);

  always_comb begin
    rd_rsp                       = '0;
    rd_rsp.address               = {local_tile_id, fab.Req.address[23:0]};
    rd_rsp.opcode                = RD_RSP;
    rd_rsp.data                  = in_range ? mem_q[idx] : OOR_RD_DATA;
    rd_rsp.requestor_id          = fab.Req.address;
    rd_rsp.next_tile_fifo_arb_id = fab.Req.next_tile_fifo_arb_id;
  end

  always_comb begin
    addr_err_d = addr_err_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    if (accept) begin
      if (misaligned || !(is_wr || is_rd) || !in_range) addr_err_d = 1'b1;
      if (is_wr) wr_cnt_d = sat_inc16(wr_cnt_q);
      if (is_rd) rd_cnt_d = sat_inc16(rd_cnt_q);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      addr_err_q <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pipe_vld_q <= '0;
    end else begin
      addr_err_q    <= addr_err_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      pipe_vld_q[0] <= accept && is_rd;
      for (int i = 1; i < RSP_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Payload stages and the array carry no reset; only the valid bits matter.
  always_ff @(posedge Clock) begin
    pipe_trans_q[0] <= rd_rsp;
    for (int i = 1; i < RSP_LATENCY; i++) pipe_trans_q[i] <= pipe_trans_q[i-1];
  end

  always_ff @(posedge Clock) begin
    if (accept && is_wr && in_range) mem_q[idx] <= fab.Req.data;
  end

  core_rrv_fab_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .Clock       (Clock),
    .Rst         (Rst),
    .push_i      (pipe_vld_q[RSP_LATENCY-1]),
    .push_data_i (pipe_trans_q[RSP_LATENCY-1]),
    .pop_i       (fab.RspReady),
    .pop_data_o  (fab.Rsp),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign fab.RspValid = !fifo_empty;
  assign AddrErr      = addr_err_q;
  assign WrCnt        = wr_cnt_q;
  assign RdCnt        = rd_cnt_q;

endmodule
